sccb_init_seq: RTL and testbench

Register-initialisation sequencer for the OV7670 camera, sitting directly upstream of the SCCB write engine. It walks an external table of 16-bit register/value pairs and prepends the 8-bit slave address to each pair. It hands every 24-bit word to the write engine through its `SCCB_req`/`SCCB_busy` handshake, spaces writes by programmable gaps (longer after a sensor soft reset), and flags completion or handshake failure to the rest of the capture pipeline.

---
 rtl/sccb_init_seq.sv | 207 ++++++++++++++++++++
 tb/tb_sccb_init_seq.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_init_seq.sv
// sccb_init_seq: walks a table of {reg, value} pairs after power-up and hands
// each one, prefixed with the SCCB slave address, to the SCCB write engine.
// Between writes it waits a fixed gap, or a longer gap after a sensor soft reset.
// If the engine does not respond, the same entry is re-requested; after the
// third miss the sequencer stops and raises init_err.
//
// Ports:
//   CLK, RST_N   : clock, asynchronous active-low reset
//   init_start   : one-cycle restart pulse; honoured only in DONE
//   rom_addr     : table index (registered)
//   rom_data     : {reg, value}; valid one cycle after rom_addr changes
//   SCCB_busy    : write-engine busy flag
//   SCCB_req     : one-cycle write request
//   sccb_data    : {SLAVE_ADDR, reg, value} for the write engine
//   init_done    : sequence finished successfully
//   init_err     : sequence aborted after repeated handshake failures
//   cfg_busy     : sequencer active (low only in DONE)
module sccb_init_seq #(
  parameter logic [7:0]  SLAVE_ADDR     = 8'h42,
  parameter logic [7:0]  REG_NUM        = 8'd3,
  parameter logic [19:0] POWER_UP_DELAY = 20'd10,
  parameter logic [19:0] GAP_DELAY      = 20'd4,
  parameter logic [19:0] RESET_DELAY    = 20'd20,
  parameter logic [3:0]  ACK_TIMEOUT    = 4'd15
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        init_start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  input  logic        SCCB_busy,
  output logic        SCCB_req,
  output logic [23:0] sccb_data,
  output logic        init_done,
  output logic        init_err,
  output logic        cfg_busy
);

  localparam int unsigned DLY_W   = 20;
  localparam int unsigned TO_W    = 4;
  localparam int unsigned RTRY_W  = 2;
  localparam int unsigned IDX_W   = 8;
  localparam int unsigned WORD_W  = 24;
  // Retry count at which the next timeout is the third one for this entry.
  localparam logic [RTRY_W-1:0] RETRY_LAST = RTRY_W'(2);
  localparam logic [15:0]       END_MARK   = 16'hFFFF;
  localparam logic [7:0]        REG_COM7   = 8'h12;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_FETCH_A,
    S_FETCH_D,
    S_REQ,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_GAP,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [DLY_W-1:0]    dly_q, dly_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic [RTRY_W-1:0]   retry_q, retry_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                req_q, req_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                soft_rst_c;

  // A write of COM7 with bit7 set resets the sensor and needs the long gap.
  assign soft_rst_c = (data_q[15:8] == REG_COM7) && data_q[7];

  // State and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_PWRUP;
      dly_q   <= '0;
      to_q    <= '0;
      retry_q <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      to_q    <= to_d;
      retry_q <= retry_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      req_q   <= req_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    to_d    = to_q;
    retry_d = retry_q;
    idx_d   = idx_q;
    data_d  = data_q;
    done_d  = done_q;
    err_d   = err_q;

    case (state_q)
      S_PWRUP: begin
        if (dly_q == POWER_UP_DELAY - DLY_W'(1)) begin
          dly_d   = '0;
          state_d = S_FETCH_A;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end

      // rom_addr already holds idx; the table answers during FETCH_D.
      S_FETCH_A: state_d = S_FETCH_D;

      S_FETCH_D: begin
        if (rom_data == END_MARK) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          data_d  = {SLAVE_ADDR, rom_data};
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        to_d    = '0;
        state_d = S_WAIT_ACK;
      end

      S_WAIT_ACK: begin
        if (SCCB_busy) begin
          state_d = S_WAIT_DONE;
        end else if (to_q + TO_W'(1) == ACK_TIMEOUT) begin
          to_d = '0;
          if (retry_q == RETRY_LAST) begin
            retry_d = '0;
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            retry_d = retry_q + RTRY_W'(1);
            state_d = S_REQ;
          end
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end

      S_WAIT_DONE: begin
        if (!SCCB_busy) begin
          retry_d = '0;
          dly_d   = soft_rst_c ? RESET_DELAY : GAP_DELAY;
          state_d = S_GAP;
        end
      end

      // dly_q counts the remaining gap cycles including the current one.
      S_GAP: begin
        if (dly_q <= DLY_W'(1)) begin
          if (idx_q == REG_NUM - IDX_W'(1)) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_FETCH_A;
          end
        end else begin
          dly_d = dly_q - DLY_W'(1);
        end
      end

      S_DONE: begin
        if (init_start) begin
          idx_d   = '0;
          retry_d = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = S_FETCH_A;
        end
      end

      default: state_d = S_PWRUP;
    endcase

    // Registered outputs that track the state being entered.
    req_d  = (state_d == S_REQ);
    busy_d = (state_d != S_DONE);
  end

  assign rom_addr  = idx_q;
  assign sccb_data = data_q;
  assign SCCB_req  = req_q;
  assign init_done = done_q;
  assign init_err  = err_q;
  assign cfg_busy  = busy_q;

endmodule

// File: tb/tb_sccb_init_seq.sv
// tb_sccb_init_seq: directed bench for sccb_init_seq with a table ROM model
// (one-cycle read latency) and a write-engine model that raises busy one
// cycle after a request for BUSY_LEN cycles, optionally ignoring the first
// ign_cfg requests after reset.
module tb_sccb_init_seq;

  localparam int unsigned BUSY_LEN = 40;
  localparam int unsigned NVEC     = 6;
  localparam int          PU_LAT   = 12;  // POWER_UP_DELAY + 2

  logic        CLK;
  logic        RST_N;
  logic        init_start;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        SCCB_busy;
  logic        SCCB_req;
  logic [23:0] sccb_data;
  logic        init_done;
  logic        init_err;
  logic        cfg_busy;

  sccb_init_seq dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .init_start (init_start),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .SCCB_busy  (SCCB_busy),
    .SCCB_req   (SCCB_req),
    .sccb_data  (sccb_data),
    .init_done  (init_done),
    .init_err   (init_err),
    .cfg_busy   (cfg_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  // ---------------- ROM and write-engine model ----------------
  logic [15:0] rom [0:255];
  int          ign_cfg;
  int          seen;
  int          bcnt;
  logic        pend;
  logic [7:0]  addr_prev;
  int          busy_viol;
  int          req_cyc [$];
  logic [23:0] req_dat [$];
  logic [7:0]  req_addr [$];
  int          fall_cyc [$];

  initial begin
    SCCB_busy = 1'b0;
    rom_data  = '0;
    seen      = 0;
    bcnt      = 0;
    pend      = 1'b0;
    addr_prev = '0;
    busy_viol = 0;
  end

  always @(negedge CLK) begin
    if (!RST_N) begin
      SCCB_busy = 1'b0;
      bcnt      = 0;
      pend      = 1'b0;
      seen      = 0;
      addr_prev = '0;
      rom_data  = '0;
    end else begin
      if (SCCB_req && SCCB_busy) busy_viol++;
      if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) begin
          SCCB_busy = 1'b0;
          fall_cyc.push_back(cyc);
        end
      end
      if (pend) begin
        pend      = 1'b0;
        SCCB_busy = 1'b1;
        bcnt      = BUSY_LEN;
      end
      if (SCCB_req) begin
        req_cyc.push_back(cyc);
        req_dat.push_back(sccb_data);
        req_addr.push_back(rom_addr);
        if (seen >= ign_cfg) pend = 1'b1;
        seen++;
      end
      rom_data  = rom[addr_prev];
      addr_prev = rom_addr;
    end
  end

  // ---------------- checking helpers ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int rel_cyc;
  int base;
  int fbase;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic load_tbl(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[0] = a;
    rom[1] = b;
    rom[2] = c;
  endtask

  task automatic do_reset();
    tick();
    RST_N = 1'b0;
    tick();
    tick();
    RST_N   = 1'b1;
    rel_cyc = cyc;
    base    = req_cyc.size();
    fbase   = fall_cyc.size();
  endtask

  task automatic wait_done(input string name, input int maxc);
    int k;
    k = 0;
    while (cfg_busy && k < maxc) begin
      tick();
      k++;
    end
    check(name, 32'(cfg_busy), 32'(0));
  endtask

  task automatic wait_reqs(input string name, input int target, input int maxc);
    int k;
    k = 0;
    while (req_cyc.size() < target && k < maxc) begin
      tick();
      k++;
    end
    check(name, 32'(req_cyc.size() >= target), 32'(1));
  endtask

  task automatic pulse_start(output int p);
    init_start = 1'b1;
    p          = cyc;
    tick();
    init_start = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] t0, t1, t2;
    int          ign;
    int          n_req;
    logic [23:0] w0, w1, w2;
    logic        done;
    logic        err;
    logic [7:0]  last_addr;
    int          sp_rr;   // req[1] - req[0], -1 = skip
    int          sp_fr;   // req[1] - fall[0], -1 = skip
    int          sp_fr2;  // req[2] - fall[1], -1 = skip
  } vec_t;

  vec_t vecs [NVEC];

  initial begin
    int          nr;
    int          nf;
    int          p;
    int          b2;
    logic [23:0] ew [3];

    RST_N      = 1'b0;
    init_start = 1'b0;
    ign_cfg    = 0;

    // nominal: soft reset first, so long gap then short gap
    vecs[0] = '{16'h1280, 16'h1101, 16'h3A04, 0,    3, 24'h421280, 24'h421101, 24'h423A04, 1'b1, 1'b0, 8'd2, -1, 23, 7};
    // end marker at entry 1
    vecs[1] = '{16'h1101, 16'hFFFF, 16'h3A04, 0,    1, 24'h421101, 24'h0,      24'h0,      1'b1, 1'b0, 8'd1, -1, -1, -1};
    // first request ignored, retried after the timeout
    vecs[2] = '{16'h1280, 16'h1101, 16'h3A04, 1,    4, 24'h421280, 24'h421280, 24'h421101, 1'b1, 1'b0, 8'd2, 16, -1, -1};
    // engine never answers
    vecs[3] = '{16'h1280, 16'h1101, 16'h3A04, 1000, 3, 24'h421280, 24'h421280, 24'h421280, 1'b0, 1'b1, 8'd0, 16, -1, -1};
    // empty table
    vecs[4] = '{16'hFFFF, 16'h1101, 16'h3A04, 0,    0, 24'h0,      24'h0,      24'h0,      1'b1, 1'b0, 8'd0, -1, -1, -1};
    // COM7 without bit7: short gap everywhere
    vecs[5] = '{16'h1200, 16'h1101, 16'h3A04, 0,    3, 24'h421200, 24'h421101, 24'h423A04, 1'b1, 1'b0, 8'd2, -1, 7, 7};

    // reset values while held in reset
    load_tbl(16'h1280, 16'h1101, 16'h3A04);
    tick();
    tick();
    check("rst_rom_addr",  32'(rom_addr),  32'(0));
    check("rst_sccb_data", 32'(sccb_data), 32'(0));
    check("rst_req",       32'(SCCB_req),  32'(0));
    check("rst_done",      32'(init_done), 32'(0));
    check("rst_err",       32'(init_err),  32'(0));
    check("rst_cfg_busy",  32'(cfg_busy),  32'(1));

    for (int v = 0; v < int'(NVEC); v++) begin
      load_tbl(vecs[v].t0, vecs[v].t1, vecs[v].t2);
      ign_cfg = vecs[v].ign;
      do_reset();
      wait_done($sformatf("v%0d_finish", v), 3000);
      nr    = req_cyc.size() - base;
      nf    = fall_cyc.size() - fbase;
      ew[0] = vecs[v].w0;
      ew[1] = vecs[v].w1;
      ew[2] = vecs[v].w2;
      check($sformatf("v%0d_nreq", v), 32'(nr), 32'(vecs[v].n_req));
      for (int i = 0; i < 3; i++) begin
        if (i < nr && i < vecs[v].n_req)
          check($sformatf("v%0d_word%0d", v, i), 32'(req_dat[base+i]), 32'(ew[i]));
      end
      check($sformatf("v%0d_done", v), 32'(init_done), 32'(vecs[v].done));
      check($sformatf("v%0d_err", v),  32'(init_err),  32'(vecs[v].err));
      check($sformatf("v%0d_addr", v), 32'(rom_addr),  32'(vecs[v].last_addr));
      if (nr > 0)
        check($sformatf("v%0d_first_lat", v), 32'(req_cyc[base] - rel_cyc), 32'(PU_LAT));
      if (vecs[v].sp_rr >= 0 && nr >= 2)
        check($sformatf("v%0d_req_spacing", v), 32'(req_cyc[base+1] - req_cyc[base]), 32'(vecs[v].sp_rr));
      if (vecs[v].sp_fr >= 0 && nr >= 2 && nf >= 1)
        check($sformatf("v%0d_gap1", v), 32'(req_cyc[base+1] - fall_cyc[fbase]), 32'(vecs[v].sp_fr));
      if (vecs[v].sp_fr2 >= 0 && nr >= 3 && nf >= 2)
        check($sformatf("v%0d_gap2", v), 32'(req_cyc[base+2] - fall_cyc[fbase+1]), 32'(vecs[v].sp_fr2));
      if (vecs[v].err && nr >= 3)
        check($sformatf("v%0d_req_spacing2", v), 32'(req_cyc[base+2] - req_cyc[base+1]), 32'(16));
    end

    // restart: pulse mid-GAP is ignored, pulse in DONE restarts from entry 0
    load_tbl(16'h1280, 16'h1101, 16'h3A04);
    ign_cfg = 0;
    do_reset();
    begin
      int k;
      k = 0;
      while (fall_cyc.size() <= fbase && k < 200) begin
        tick();
        k++;
      end
      check("rs_fall_seen", 32'(fall_cyc.size() > fbase), 32'(1));
    end
    tick();
    tick();
    tick();
    pulse_start(p);
    wait_done("rs_finish", 3000);
    check("rs_nreq", 32'(req_cyc.size() - base), 32'(3));
    if (req_cyc.size() >= base + 2)
      check("rs_word1", 32'(req_dat[base+1]), 32'(24'h421101));
    tick();
    pulse_start(p);
    check("rs_done_clr", 32'(init_done), 32'(0));
    check("rs_cfg_busy", 32'(cfg_busy),  32'(1));
    wait_reqs("rs_req_seen", base + 4, 100);
    if (req_cyc.size() >= base + 4) begin
      check("rs_req_lat",  32'(req_cyc[base+3] - p), 32'(3));
      check("rs_req_addr", 32'(req_addr[base+3]),    32'(0));
      check("rs_req_word", 32'(req_dat[base+3]),     32'(24'h421280));
    end
    wait_done("rs_finish2", 3000);
    check("rs_done2", 32'(init_done), 32'(1));

    // failure, then init_start clears init_err and a clean run follows
    ign_cfg = 1000;
    do_reset();
    wait_done("fr_finish", 3000);
    check("fr_err", 32'(init_err), 32'(1));
    ign_cfg = 0;
    pulse_start(p);
    check("fr_err_clr", 32'(init_err), 32'(0));
    wait_done("fr_finish2", 3000);
    check("fr_done2", 32'(init_done), 32'(1));
    check("fr_err2",  32'(init_err),  32'(0));
    check("fr_nreq",  32'(req_cyc.size() - base), 32'(6));

    // asynchronous reset during WAIT_DONE of entry 1
    do_reset();
    wait_reqs("ar_req2_seen", base + 2, 300);
    for (int i = 0; i < 5; i++) tick();
    RST_N = 1'b0;
    #1;
    check("ar_req",       32'(SCCB_req),  32'(0));
    check("ar_sccb_data", 32'(sccb_data), 32'(0));
    check("ar_rom_addr",  32'(rom_addr),  32'(0));
    check("ar_done",      32'(init_done), 32'(0));
    check("ar_cfg_busy",  32'(cfg_busy),  32'(1));
    tick();
    RST_N   = 1'b1;
    rel_cyc = cyc;
    b2      = req_cyc.size();
    wait_reqs("ar_req_seen", b2 + 1, 100);
    if (req_cyc.size() >= b2 + 1) begin
      check("ar_req_lat",  32'(req_cyc[b2] - rel_cyc), 32'(PU_LAT));
      check("ar_req_word", 32'(req_dat[b2]),           32'(24'h421280));
    end
    wait_done("ar_finish", 3000);

    check("req_while_busy", 32'(busy_viol), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
